// File: rtl/maxpool_layer_pkg.sv
// Shared pooling/activation pipeline helpers: signed max and the
// elastic single-register output handshake.
package maxpool_layer_pkg;

  localparam int unsigned MaxWordW = 64;

  typedef logic signed [MaxWordW-1:0] wide_t;

  // Callers sign-extend their words to wide_t and truncate the result back.
  function automatic wide_t smax(input wide_t a, input wide_t b);
    return (a > b) ? a : b;
  endfunction

  // A stage may accept when its output register is empty or draining this cycle.
  function automatic logic elastic_ready(input logic valid_r, input logic ready_i);
    return ~valid_r | ready_i;
  endfunction

endpackage

// File: rtl/maxpool_layer_pool_line_buffer.sv
// Half-width line buffer of per-channel partial maxima; registered write,
// combinational read. Not reset: every entry is written before it is read.
module pool_line_buffer #(
  parameter int unsigned Depth    = 79,
  parameter int unsigned Width    = 32,
  parameter int unsigned Channels = 1,
  localparam int unsigned IdxW    = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic                                     clk_i,
  input  logic                                     we_i,
  input  logic        [IdxW-1:0]                   widx_i,
  input  logic signed [Channels-1:0][Width-1:0]    wdata_i,
  input  logic        [IdxW-1:0]                   ridx_i,
  output logic signed [Channels-1:0][Width-1:0]    rdata_o
);

  logic [Channels-1:0][Width-1:0] mem [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[widx_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[ridx_i];

endmodule

// File: rtl/maxpool_layer.sv
// Streaming 2x2 stride-2 max-pool with optional ReLU clamp and an elastic
// single-register valid/ready output.
module maxpool_layer
  import maxpool_layer_pkg::*;
#(
  parameter int unsigned LineWidthPx = 158,
  parameter int unsigned LineCountPx = 118,
  parameter int unsigned Channels    = 1,
  parameter int unsigned Width       = 32,
  parameter bit          Relu        = 1'b1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  valid_i,
  output logic                                  ready_o,
  input  logic signed [Channels-1:0][Width-1:0] data_i,
  output logic                                  valid_o,
  input  logic                                  ready_i,
  output logic signed [Channels-1:0][Width-1:0] data_o
);

  localparam int unsigned HalfW = LineWidthPx / 2;
  localparam int unsigned XW    = (LineWidthPx > 1) ? $clog2(LineWidthPx) : 1;
  localparam int unsigned YW    = (LineCountPx > 1) ? $clog2(LineCountPx) : 1;
  localparam int unsigned IW    = (HalfW > 1) ? $clog2(HalfW) : 1;

  logic [XW-1:0] x_pos;
  logic [YW-1:0] y_pos;
  logic          in_fire;
  logic          produce;
  logic          lb_we;
  logic [IW-1:0] lb_idx;
  logic          valid_r;

  logic signed [Channels-1:0][Width-1:0] hmax_r;
  logic signed [Channels-1:0][Width-1:0] pair_max;
  logic signed [Channels-1:0][Width-1:0] lb_rdata;
  logic signed [Channels-1:0][Width-1:0] pooled;
  logic signed [Channels-1:0][Width-1:0] data_r;

  assign ready_o = elastic_ready(valid_r, ready_i);
  assign in_fire = valid_i & ready_o;
  assign produce = x_pos[0] & y_pos[0];
  assign lb_we   = in_fire & x_pos[0] & ~y_pos[0];
  assign lb_idx  = IW'(x_pos >> 1);
  assign valid_o = valid_r;
  assign data_o  = data_r;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      x_pos <= '0;
      y_pos <= '0;
    end else if (in_fire) begin
      if (x_pos == XW'(LineWidthPx - 1)) begin
        x_pos <= '0;
        y_pos <= (y_pos == YW'(LineCountPx - 1)) ? '0 : y_pos + 1'b1;
      end else begin
        x_pos <= x_pos + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hmax_r <= '0;
    end else if (in_fire && !x_pos[0]) begin
      hmax_r <= data_i;
    end
  end

  pool_line_buffer #(
    .Depth    (HalfW),
    .Width    (Width),
    .Channels (Channels)
  ) u_line_buf (
    .clk_i   (clk_i),
    .we_i    (lb_we),
    .widx_i  (lb_idx),
    .wdata_i (pair_max),
    .ridx_i  (lb_idx),
    .rdata_o (lb_rdata)
  );

  // pair_max feeds both the line-buffer write (even rows) and the final compare (odd rows).
  always_comb begin
    pair_max = '0;
    pooled   = '0;
    for (int unsigned c = 0; c < Channels; c++) begin
      pair_max[c] = Width'(smax(wide_t'($signed(hmax_r[c])), wide_t'($signed(data_i[c]))));
      pooled[c]   = Width'(smax(wide_t'($signed(lb_rdata[c])), wide_t'($signed(pair_max[c]))));
      if (Relu && pooled[c][Width-1]) begin
        pooled[c] = '0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_r <= 1'b0;
      data_r  <= '0;
    end else if (ready_o) begin
      valid_r <= in_fire & produce;
      data_r  <= pooled;
    end
  end

endmodule
